// File: rtl/serial_add_ctrl_pkg.sv
// Project constants shared by the serial adder controller and its bench.
// Holds the FSM state encoding and the bit-counter sizing helper.
// No ports; imported with import serial_add_ctrl_pkg::*.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One extra bit so the count after the last bit (== width) is representable.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Purpose: single-bit full adder used as the serial adder's arithmetic slice.
// Latency: combinational. Backpressure: none.
// Ports: a, b, cin (bit inputs) -> s (sum bit), cout (carry out).
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: bit-serial {cout,sum} = a + b + cin, LSB first, one bit per clock.
// Latency: WIDTH cycles in RUN plus one DONE cycle; start is ignored while busy.
// Ports: clk, rst (sync, active-high), start, a, b, cin in; busy, done, sum, cout out.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_nxt;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             a_bit;
   logic             b_bit;
   logic             fa_s;
   logic             fa_cout;

   // Bit select by counter, written as a compare loop so the counter's
   // extra terminal-count bit never widens the index.
   always_comb begin
      a_bit   = 1'b0;
      b_bit   = 1'b0;
      res_nxt = res_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(i)) begin
            a_bit      = a_q[i];
            b_bit      = b_q[i];
            res_nxt[i] = fa_s;
         end
      end
   end

   fullAdder u_fa (
      .a    (a_bit),
      .b    (b_bit),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: operands are captured only on an accepted start, so later
   // changes on a/b/cin and restarts while busy have no effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  res_q   <= '0;
                  cnt     <= '0;
               end
            end
            RUN: begin
               res_q   <= res_nxt;
               carry_q <= fa_cout;
               cnt     <= cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign sum  = res_q;
   assign cout = carry_q;

endmodule
